// File: rtl/axil_pkg.sv
// -----------------------------------------------------------------------------
// axil_pkg
// Shared types for the AXI4-Lite register file slice: bus response codes,
// write/read FSM state encodings and the default register count.
// -----------------------------------------------------------------------------
package axil_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_t;

   typedef enum logic {
      W_IDLE,
      W_RESP
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_t;

   localparam int DEFAULT_NUM_REGS = 16;

endpackage

// File: rtl/axil_regfile_if.sv
// -----------------------------------------------------------------------------
// axil_regfile_if
// AXI4-Lite signal bundle. The master modport drives addresses, write data and
// response readies; the slave modport drives readies, responses and read data.
//   AW: awaddr, awvalid, awready        W: wdata, wstrb, wvalid, wready
//   B : bresp, bvalid, bready           AR: araddr, arvalid, arready
//   R : rdata, rresp, rvalid, rready
// -----------------------------------------------------------------------------
interface axil_regfile_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axil_regfile_mem.sv
// -----------------------------------------------------------------------------
// axil_regfile_mem
// Register array with one byte-strobed write port and one combinational read
// port. All words clear on reset.
//   clk, rst_n : clock, async active-low reset
//   we, widx, wdata, wstrb : write enable, word index, data, byte-lane strobes
//   ridx, rdata : read word index and combinational read data
// -----------------------------------------------------------------------------
module axil_regfile_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 16,
   parameter int IDX_W      = $clog2(NUM_REGS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    we,
   input  logic [IDX_W-1:0]        widx,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic [IDX_W-1:0]        ridx,
   output logic [DATA_WIDTH-1:0]   rdata
);
   localparam int BYTES = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (we) begin
         for (int b = 0; b < BYTES; b++)
            if (wstrb[b]) regs[widx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
   end

   // Read sees the value before any write landing on the same edge.
   assign rdata = regs[ridx];

endmodule

// File: rtl/axil_regfile.sv
// -----------------------------------------------------------------------------
// axil_regfile
// AXI4-Lite slave holding NUM_REGS data-width registers. Independent write and
// read FSMs; out-of-range accesses answer SLVERR (reads return zero data).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : AXI4-Lite slave side (AW, W, B, AR, R channels)
// -----------------------------------------------------------------------------
module axil_regfile
   import axil_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = DEFAULT_NUM_REGS
) (
   input  logic           clk,
   input  logic           rst_n,
   axil_regfile_if.slave  bus
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int IDX_W = $clog2(NUM_REGS);
   localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(NUM_REGS * BYTES);

   // Full-width compare so that upper address bits never alias onto registers.
   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return a < LIMIT;
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
      return IDX_W'(a >> OFF_W);
   endfunction

   wr_state_t wr_state, wr_next;
   rd_state_t rd_state, rd_next;

   // Holds readies low during reset and goes high on the first edge after it.
   logic live;

   logic                  aw_held, w_held;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [BYTES-1:0]      w_strb_q;
   resp_t                 bresp_q, rresp_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic                  aw_hs, w_hs, ar_hs, commit, mem_we;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data, mem_rdata;
   logic [BYTES-1:0]      wr_strb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) live <= 1'b0;
      else        live <= 1'b1;
   end

   assign bus.awready = live && (wr_state == W_IDLE) && !aw_held;
   assign bus.wready  = live && (wr_state == W_IDLE) && !w_held;
   assign bus.arready = live && (rd_state == R_IDLE);

   assign aw_hs = bus.awvalid && bus.awready;
   assign w_hs  = bus.wvalid  && bus.wready;
   assign ar_hs = bus.arvalid && bus.arready;

   // A channel handshaking this cycle bypasses its holding register.
   assign wr_addr = aw_hs ? bus.awaddr : aw_addr_q;
   assign wr_data = w_hs  ? bus.wdata  : w_data_q;
   assign wr_strb = w_hs  ? bus.wstrb  : w_strb_q;
   assign commit  = (wr_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
   assign mem_we  = commit && in_range(wr_addr);

   axil_regfile_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (mem_we),
      .widx  (word_idx(wr_addr)),
      .wdata (wr_data),
      .wstrb (wr_strb),
      .ridx  (word_idx(bus.araddr)),
      .rdata (mem_rdata)
   );

   // Write FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wr_state <= W_IDLE;
      else        wr_state <= wr_next;
   end

   always_comb begin
      wr_next    = wr_state;
      bus.bvalid = 1'b0;
      case (wr_state)
         W_IDLE: if (commit) wr_next = W_RESP;
         W_RESP: begin
            bus.bvalid = 1'b1;
            if (bus.bready) wr_next = W_IDLE;
         end
         default: wr_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bresp_q   <= OKAY;
      end else if (wr_state == W_IDLE) begin
         if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= bus.awaddr;
         end
         if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= bus.wdata;
            w_strb_q <= bus.wstrb;
         end
         if (commit) bresp_q <= in_range(wr_addr) ? OKAY : SLVERR;
      end else if (bus.bready) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
      end
   end

   assign bus.bresp = bresp_q;

   // Read FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_state <= R_IDLE;
      else        rd_state <= rd_next;
   end

   always_comb begin
      rd_next    = rd_state;
      bus.rvalid = 1'b0;
      case (rd_state)
         R_IDLE: if (ar_hs) rd_next = R_DATA;
         R_DATA: begin
            bus.rvalid = 1'b1;
            if (bus.rready) rd_next = R_IDLE;
         end
         default: rd_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
         rresp_q <= OKAY;
      end else if (ar_hs) begin
         rdata_q <= in_range(bus.araddr) ? mem_rdata : '0;
         rresp_q <= in_range(bus.araddr) ? OKAY : SLVERR;
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.rresp = rresp_q;

endmodule

// File: tb/tb_axil_regfile.sv
// -----------------------------------------------------------------------------
// tb_axil_regfile
// Scenario bench for axil_regfile: a bench-side register model produces the
// expected responses, which are queued when a transaction is issued and
// compared when the DUT answers.
// -----------------------------------------------------------------------------
module tb_axil_regfile;
   import axil_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   axil_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   axil_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] model [16];
   logic [1:0]  exp_b_q [$];
   logic [31:0] exp_rd_q [$];
   logic [1:0]  exp_rr_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic in_rng(input logic [31:0] a);
      return a < 32'h40;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      if (in_rng(a))
         for (int b = 0; b < 4; b++)
            if (s[b]) model[a[5:2]][b*8 +: 8] = d[b*8 +: 8];
   endtask

   // Issue a write; W leads AW by w_lead cycles; B is back-pressured b_delay cycles.
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int w_lead, input int b_delay);
      bit aw_done = 0, w_done = 0, aw_go, w_go;
      int cyc = 0;
      logic [1:0] b0, exp;
      exp_b_q.push_back(in_rng(a) ? OKAY : SLVERR);
      @(negedge clk);
      bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
      bus.wvalid = 1'b1; bus.awvalid = (w_lead == 0);
      while (!(aw_done && w_done)) begin
         aw_go = bus.awvalid && bus.awready;
         w_go  = bus.wvalid && bus.wready;
         @(negedge clk);
         cyc++;
         if (aw_go) begin aw_done = 1; bus.awvalid = 1'b0; end
         if (w_go)  begin w_done = 1;  bus.wvalid  = 1'b0; end
         if (w_done && !aw_done) chk("wready_low_while_w_held", {31'b0, bus.wready}, 32'd0);
         if (!aw_done && cyc >= w_lead) bus.awvalid = 1'b1;
         if (cyc > 50) begin
            chk("write_handshake_timeout", 32'd1, 32'd0);
            bus.awvalid = 1'b0; bus.wvalid = 1'b0;
            break;
         end
      end
      chk("bvalid_latency", {31'b0, bus.bvalid}, 32'd1);
      b0 = bus.bresp;
      for (int i = 0; i < b_delay; i++) begin
         @(negedge clk);
         chk("bvalid_hold", {31'b0, bus.bvalid}, 32'd1);
         chk("bresp_hold", {30'b0, bus.bresp}, {30'b0, b0});
         chk("awready_low_in_resp", {31'b0, bus.awready}, 32'd0);
         chk("wready_low_in_resp", {31'b0, bus.wready}, 32'd0);
      end
      exp = exp_b_q.pop_front();
      chk("bresp", {30'b0, bus.bresp}, {30'b0, exp});
      if (exp == OKAY) model_write(a, d, s);
      bus.bready = 1'b1;
      @(negedge clk);
      bus.bready = 1'b0;
      chk("bvalid_clear", {31'b0, bus.bvalid}, 32'd0);
   endtask

   // Issue a read; R is back-pressured r_delay cycles.
   task automatic axi_read(input logic [31:0] a, input int r_delay);
      bit ar_go;
      int cyc = 0;
      logic [31:0] d0;
      exp_rd_q.push_back(in_rng(a) ? model[a[5:2]] : 32'h0);
      exp_rr_q.push_back(in_rng(a) ? OKAY : SLVERR);
      @(negedge clk);
      bus.araddr = a; bus.arvalid = 1'b1;
      forever begin
         ar_go = bus.arready;
         @(negedge clk);
         cyc++;
         if (ar_go) break;
         if (cyc > 50) begin
            chk("read_handshake_timeout", 32'd1, 32'd0);
            break;
         end
      end
      bus.arvalid = 1'b0;
      chk("rvalid_latency", {31'b0, bus.rvalid}, 32'd1);
      d0 = bus.rdata;
      for (int i = 0; i < r_delay; i++) begin
         @(negedge clk);
         chk("rvalid_hold", {31'b0, bus.rvalid}, 32'd1);
         chk("rdata_hold", bus.rdata, d0);
         chk("arready_low_in_data", {31'b0, bus.arready}, 32'd0);
      end
      chk("rdata", bus.rdata, exp_rd_q.pop_front());
      chk("rresp", {30'b0, bus.rresp}, {30'b0, exp_rr_q.pop_front()});
      bus.rready = 1'b1;
      @(negedge clk);
      bus.rready = 1'b0;
      chk("rvalid_clear", {31'b0, bus.rvalid}, 32'd0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 16; i++) model[i] = 32'h0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rst_awready", {31'b0, bus.awready}, 32'd0);
         chk("rst_wready", {31'b0, bus.wready}, 32'd0);
         chk("rst_arready", {31'b0, bus.arready}, 32'd0);
         chk("rst_bvalid", {31'b0, bus.bvalid}, 32'd0);
         chk("rst_rvalid", {31'b0, bus.rvalid}, 32'd0);
      end
      chk("rst_rdata", bus.rdata, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_awready", {31'b0, bus.awready}, 32'd1);
      chk("post_rst_wready", {31'b0, bus.wready}, 32'd1);
      chk("post_rst_arready", {31'b0, bus.arready}, 32'd1);
      for (int i = 0; i < 16; i++) axi_read(32'(i * 4), 0);
   endtask

   task automatic test_full_write();
      axi_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0);
      exp_rd_q.push_back(32'hDEADBEEF);
      exp_rr_q.push_back(OKAY);
      axi_read(32'h08, 0);
      // The explicitly pushed constant and the model entry must both match.
      chk("full_write_readback", bus.rdata, exp_rd_q.pop_front());
      void'(exp_rr_q.pop_front());
   endtask

   task automatic test_strobe_wfirst();
      axi_write(32'h08, 32'h11223344, 4'h5, 3, 0);
      chk("strobe_model", model[2], 32'hDE22BE44);
      axi_read(32'h08, 0);
      axi_write(32'h10, 32'hFFFFFFFF, 4'h0, 0, 0);
      axi_read(32'h10, 0);
   endtask

   task automatic test_out_of_range();
      axi_write(32'h40, 32'hCAFEF00D, 4'hF, 0, 0);
      axi_read(32'h00, 0);
      axi_read(32'h08, 0);
      axi_read(32'h40, 0);
      axi_read(32'h1000_0008, 0);
      axi_write(32'h3C, 32'h0BADC0DE, 4'hF, 0, 0);
      axi_read(32'h3E, 0);
   endtask

   task automatic test_backpressure();
      axi_write(32'h14, 32'h5A5A0001, 4'hF, 0, 4);
      axi_read(32'h14, 4);
      axi_write(32'h44, 32'h1, 4'hF, 2, 4);
   endtask

   task automatic test_collision();
      axi_write(32'h0C, 32'h12345678, 4'hF, 0, 0);
      exp_rd_q.push_back(model[3]);
      exp_rr_q.push_back(OKAY);
      exp_b_q.push_back(OKAY);
      @(negedge clk);
      chk("coll_ready_all", {29'b0, bus.awready, bus.wready, bus.arready}, 32'd7);
      bus.awaddr = 32'h0C; bus.wdata = 32'hA5A5A5A5; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      bus.araddr = 32'h0C; bus.arvalid = 1'b1;
      @(negedge clk);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      chk("coll_bvalid", {31'b0, bus.bvalid}, 32'd1);
      chk("coll_rvalid", {31'b0, bus.rvalid}, 32'd1);
      chk("coll_bresp", {30'b0, bus.bresp}, {30'b0, exp_b_q.pop_front()});
      chk("coll_old_value", bus.rdata, exp_rd_q.pop_front());
      chk("coll_rresp", {30'b0, bus.rresp}, {30'b0, exp_rr_q.pop_front()});
      model_write(32'h0C, 32'hA5A5A5A5, 4'hF);
      bus.bready = 1'b1; bus.rready = 1'b1;
      @(negedge clk);
      bus.bready = 1'b0; bus.rready = 1'b0;
      axi_read(32'h0C, 0);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus.awaddr = 32'h04; bus.wdata = 32'h77778888; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      @(negedge clk);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      chk("mid_bvalid_before", {31'b0, bus.bvalid}, 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("mid_bvalid_drop", {31'b0, bus.bvalid}, 32'd0);
      for (int i = 0; i < 16; i++) model[i] = 32'h0;
      // Leave an AW pending into reset to confirm it is discarded.
      @(negedge clk);
      bus.awaddr = 32'h20; bus.awvalid = 1'b1;
      @(negedge clk);
      bus.awvalid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_awready_after", {31'b0, bus.awready}, 32'd1);
      chk("mid_bvalid_after", {31'b0, bus.bvalid}, 32'd0);
      axi_read(32'h04, 0);
      axi_read(32'h0C, 0);
      axi_write(32'h20, 32'h00C0FFEE, 4'hF, 0, 0);
      axi_read(32'h20, 0);
   endtask

   initial begin
      bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
      bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0;
      bus.rready = 1'b0;
      test_reset();
      test_full_write();
      test_strobe_wfirst();
      test_out_of_range();
      test_backpressure();
      test_collision();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/axil_regfile.md
# axil_regfile

AXI4-Lite slave register file that terminates the bus driven by the testbench master through the `dut` side of the AXI-Lite interface. Holds `NUM_REGS` word-wide registers with byte-strobe writes and independent write and read state machines. Out-of-range accesses return SLVERR. It is the first DUT behind the AXI-Lite agent and the target of the bench's scoreboard.

## Interface
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: data width; must be 32 or 64.
- `NUM_REGS`, 16: register count; must be a power of 2 and at least 2.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `awaddr` in ADDR_WIDTH, `awvalid` in 1, `awready` out 1: write address channel.
- `wdata` in DATA_WIDTH, `wstrb` in DATA_WIDTH/8, `wvalid` in 1, `wready` out 1: write data channel.
- `bresp` out 2, `bvalid` out 1, `bready` in 1: write response channel.
- `araddr` in ADDR_WIDTH, `arvalid` in 1, `arready` out 1: read address channel.
- `rdata` out DATA_WIDTH, `rresp` out 2, `rvalid` out 1, `rready` in 1: read data channel.

## Operation
- **Decode**
  - BYTES = DATA_WIDTH/8. Word index = addr >> log2(BYTES).
  - Address low bits below the word boundary are ignored.
  - Access is in range iff addr < NUM_REGS*BYTES. This compares the full ADDR_WIDTH; upper bits are not aliased.
- **Write FSM states:** W_IDLE, W_RESP.
  - In W_IDLE, AW and W are accepted independently, in either order or in the same cycle. Each is latched with an `aw_held` / `w_held` flag.
  - `awready` = W_IDLE && !aw_held. `wready` = W_IDLE && !w_held.
  - When both are held, or both handshake in the current cycle, the FSM commits and enters W_RESP.
  - Commit, in range: byte lane i is updated iff wstrb[i]; bresp = OKAY (2'b00).
  - Commit, out of range: no register changes; bresp = SLVERR (2'b10).
  - W_RESP: bvalid = 1 and bresp holds stable until bready. On bvalid && bready, the held flags clear and the FSM returns to W_IDLE.
  - wstrb = 0 in range: no change, OKAY.
- **Read FSM states:** R_IDLE, R_DATA.
  - `arready` = (state == R_IDLE).
  - On the AR handshake, rdata, rresp (OKAY or SLVERR) and the next state are registered.
  - Out of range: rdata = 0.
  - R_DATA: rvalid = 1; rdata and rresp hold until rready, then the FSM returns to R_IDLE.
- **Read/write collision**
  - The read and write FSMs are fully independent.
  - A read whose AR handshake falls in the same cycle as a write commit to the same word returns the pre-write value.
  - A read in any later cycle returns the new value.

## Timing
- **Reset:** all registers = 0. awready = wready = arready = 0 while rst_n = 0, and = 1 from the first edge after release. bvalid = rvalid = 0; bresp = rresp = 0; rdata = 0.
- **Reset mid-transaction:** the transaction is dropped with no response; held AW/W are discarded; the FSMs return to idle.
- **Write latency:** AW and W handshake in cycle N → bvalid in cycle N+1. If W arrives k cycles after AW, bvalid follows in the cycle after the W handshake.
- **Read latency:** AR handshake in cycle N → rvalid in cycle N+1.
- **Throughput:** one write per 2 cycles and one read per 2 cycles at best. Readies are low while the corresponding response is pending.
- **Outputs:** all outputs are registered; there is no combinational path from any valid input to any ready output.

## Structure
- **Shared package `axil_pkg`:**
  - `resp_t` enum with OKAY = 2'b00 and SLVERR = 2'b10.
  - `wr_state_t` and `rd_state_t` enums.
  - A `DEFAULT_NUM_REGS` constant.
- **Sub-module `axil_regfile_mem`:** register array with a byte-strobed write port and a combinational read port. The write and read FSMs stay in the top module.

## Test plan
- **Reset:** drive rst_n low for 5 cycles, then read all 16 registers → each read returns rdata = 0, rresp = OKAY; ready outputs are 0 during reset.
- **Full write and readback:** AW and W in the same cycle, addr 0x08, wdata 0xDEADBEEF, wstrb 0xF → bvalid the next cycle with OKAY. Read of 0x08 returns 0xDEADBEEF.
- **Byte strobes and W-first ordering:** present W (0x11223344, wstrb 0x5) 3 cycles before AW (addr 0x08, which holds 0xDEADBEEF) → register becomes 0xDE22BE44; bvalid follows the cycle after the AW handshake.
- **Out-of-range access:** write addr 0x40 → bresp SLVERR and no register changes. Read addr 0x40 → rresp SLVERR, rdata 0.
- **Backpressure:** hold bready = 0 for 4 cycles → bvalid and bresp stay stable and awready/wready stay 0. Hold rready = 0 for 4 cycles → rdata stays stable.
- **Collision and reset:** an AR handshake to 0x0C in the same cycle as a write commit of 0xA5A5A5A5 to 0x0C returns the old value; a following read returns 0xA5A5A5A5. Asserting rst_n low while bvalid = 1 → bvalid drops immediately.
